operand2_shift_ctrl: RTL and testbench

Upstream control stage for the combinational Shifter in the execute path. Accepts the 12-bit operand2 field of a data-processing instruction and decodes rotate-immediate, immediate-shift and register-shift forms. For register shifts it fetches Rs through a dedicated register-file read port. It presents a registered {shift_type, shift_num, x} triple to the Shifter, plus an override for results the 5-bit Shifter cannot express (shift by 32 or more, and RRX).

---
 rtl/operand2_shift_ctrl.sv | 168 ++++++++++++++++
 tb/tb_operand2_shift_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand2_shift_ctrl.sv
// rtl/operand2_shift_ctrl.sv - operand2 decode and Rs fetch ahead of the Shifter
// Build macro OPERAND2_RRX_EN: immediate ROR #0 becomes RRX through the override path.
module operand2_shift_ctrl #(
  parameter int WIDTH  = 32,
  parameter int RS_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             i_bit,
  input  logic [11:0]      operand2,
  input  logic [WIDTH-1:0] rm_data,
  input  logic             carry_in,
  output logic             rs_rd_en,
  output logic [3:0]       rs_addr,
  input  logic [WIDTH-1:0] rs_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       shift_type,
  output logic [4:0]       shift_num,
  output logic [WIDTH-1:0] shift_x,
  output logic             ovr_en,
  output logic [WIDTH-1:0] ovr_val
);

  typedef enum logic [1:0] {IDLE = 2'd0, RS_WAIT = 2'd1, OUT = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [11:0]      op2_q;
  logic [WIDTH-1:0] rm_q;
  logic [1:0]       lat_cnt;
  logic             idle, reg_form, accept, rs_done, load;
  logic [11:0]      src_op2;
  logic [WIDTH-1:0] src_rm;
  logic             src_ibit;
  logic [4:0]       amt;
  logic [1:0]       typ;
  logic [7:0]       rs_amt;
  logic [1:0]       dec_type;
  logic [4:0]       dec_num;
  logic [WIDTH-1:0] dec_x, dec_ovr_val;
  logic             dec_ovr_en;

  assign idle     = (state == IDLE);
  assign reg_form = !i_bit && operand2[4];
  assign accept   = idle && in_valid;
  assign rs_done  = (state == RS_WAIT) && (lat_cnt == 2'(RS_LAT - 1));
  assign load     = (accept && !reg_form) || rs_done;

  // Immediate forms decode straight from the inputs; register shifts decode from the latched copy.
  assign src_op2  = idle ? operand2 : op2_q;
  assign src_rm   = idle ? rm_data : rm_q;
  assign src_ibit = idle && i_bit;
  assign amt      = src_op2[11:7];
  assign typ      = src_op2[6:5];
  assign rs_amt   = rs_data[7:0];

`ifdef OPERAND2_RRX_EN
  logic unused_rs_bits;
  assign unused_rs_bits = &{1'b0, rs_data[WIDTH-1:8]};
`else
  logic unused_rs_bits;
  assign unused_rs_bits = &{1'b0, rs_data[WIDTH-1:8], carry_in};
`endif

  always_comb begin
    dec_type    = typ;
    dec_num     = 5'd0;
    dec_x       = src_rm;
    dec_ovr_en  = 1'b0;
    dec_ovr_val = '0;
    if (src_ibit) begin
      dec_type = 2'b11;
      dec_num  = {src_op2[11:8], 1'b0};
      dec_x    = {{(WIDTH-8){1'b0}}, src_op2[7:0]};
    end else if (!src_op2[4]) begin
      dec_num = amt;
      if (amt == 5'd0) begin
        case (typ)
          2'b00: dec_ovr_en = 1'b0;
          2'b01: dec_ovr_en = 1'b1;
          2'b10: begin
            dec_ovr_en  = 1'b1;
            dec_ovr_val = {WIDTH{src_rm[WIDTH-1]}};
          end
          2'b11: begin
`ifdef OPERAND2_RRX_EN
            dec_ovr_en  = 1'b1;
            dec_ovr_val = {carry_in, src_rm[WIDTH-1:1]};
`else
            dec_ovr_en  = 1'b0;
`endif
          end
          default: dec_ovr_en = 1'b0;
        endcase
      end
    end else begin
      dec_num = rs_amt[4:0];
      if (rs_amt == 8'd0) begin
        dec_type = 2'b00;
      end else if (rs_amt[7:5] != 3'd0) begin
        // ROR by 32 or more is just ROR by the low five bits, so only the other three override.
        case (typ)
          2'b00, 2'b01: dec_ovr_en = 1'b1;
          2'b10: begin
            dec_ovr_en  = 1'b1;
            dec_ovr_val = {WIDTH{src_rm[WIDTH-1]}};
          end
          default: dec_ovr_en = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = reg_form ? RS_WAIT : OUT;
      RS_WAIT: if (rs_done) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = idle;
    out_valid = (state == OUT);
    rs_rd_en  = reset_n && accept && reg_form;
    rs_addr   = rs_rd_en ? operand2[11:8] : 4'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op2_q      <= 12'd0;
      rm_q       <= '0;
      lat_cnt    <= 2'd0;
      shift_type <= 2'd0;
      shift_num  <= 5'd0;
      shift_x    <= '0;
      ovr_en     <= 1'b0;
      ovr_val    <= '0;
    end else begin
      if (accept) begin
        op2_q <= operand2;
        rm_q  <= rm_data;
      end
      if (state == RS_WAIT) lat_cnt <= lat_cnt + 2'd1;
      else                  lat_cnt <= 2'd0;
      if (load) begin
        shift_type <= dec_type;
        shift_num  <= dec_num;
        shift_x    <= dec_x;
        ovr_en     <= dec_ovr_en;
        ovr_val    <= dec_ovr_val;
      end
    end
  end

endmodule

// File: tb/tb_operand2_shift_ctrl.sv
// tb/tb_operand2_shift_ctrl.sv - randomized and directed bench for operand2_shift_ctrl
module tb_operand2_shift_ctrl;
  localparam int RS_LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, i_bit = 1'b0, carry_in = 1'b0;
  logic [11:0] operand2 = 12'd0;
  logic [31:0] rm_data = 32'd0, rs_data = 32'd0;
  logic        rs_rd_en, out_valid, out_ready = 1'b0, ovr_en;
  logic [3:0]  rs_addr;
  logic [1:0]  shift_type;
  logic [4:0]  shift_num;
  logic [31:0] shift_x, ovr_val;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] regs [16];
  logic        pv [RS_LAT];
  logic [3:0]  pa [RS_LAT];
  logic        rd_seen = 1'b0;
  logic [3:0]  addr_seen = 4'd0;

  always #5 clk = ~clk;

  operand2_shift_ctrl #(.WIDTH(32), .RS_LAT(RS_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .i_bit(i_bit), .operand2(operand2), .rm_data(rm_data), .carry_in(carry_in),
    .rs_rd_en(rs_rd_en), .rs_addr(rs_addr), .rs_data(rs_data),
    .out_valid(out_valid), .out_ready(out_ready), .shift_type(shift_type),
    .shift_num(shift_num), .shift_x(shift_x), .ovr_en(ovr_en), .ovr_val(ovr_val)
  );

  // Register-file read port: data appears RS_LAT cycles after the strobe, noise otherwise.
  always @(negedge clk) begin
    rd_seen   = rs_rd_en;
    addr_seen = rs_addr;
  end

  always @(posedge clk) begin
    #1;
    for (int i = RS_LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = rd_seen;
    pa[0] = addr_seen;
    rs_data = pv[RS_LAT-1] ? regs[pa[RS_LAT-1]] : $urandom;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] v, input int r);
    int k;
    k = r % 32;
    return (k == 0) ? v : ((v >> k) | (v << (32 - k)));
  endfunction

  // Barrel-shift semantics for any amount 0..255.
  function automatic logic [31:0] shift_arm(input int t, input int a, input logic [31:0] v);
    case (t)
      0:       return (a >= 32) ? 32'd0 : (v << a);
      1:       return (a >= 32) ? 32'd0 : (v >> a);
      2:       return (a >= 32) ? {32{v[31]}} : 32'($signed(v) >>> a);
      default: return ror32(v, a);
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic ib, input logic [11:0] op,
                                             input logic [31:0] rm, input logic c,
                                             input logic [31:0] rs);
    int t, a;
    t = int'(op[6:5]);
    if (ib) return ror32({24'd0, op[7:0]}, 2 * int'(op[11:8]));
    if (op[4]) return shift_arm(t, int'(rs[7:0]), rm);
    a = int'(op[11:7]);
    if (a == 0 && (t == 1 || t == 2)) a = 32;
    if (a == 0 && t == 3) begin
`ifdef OPERAND2_RRX_EN
      return {c, rm[31:1]};
`else
      return rm;
`endif
    end
    return shift_arm(t, a, rm);
  endfunction

  function automatic logic [31:0] dut_result();
    return ovr_en ? ovr_val : shift_arm(int'(shift_type), int'(shift_num), shift_x);
  endfunction

  task automatic send(input logic ib, input logic [11:0] op, input logic [31:0] rm,
                      input logic c, input logic [31:0] rsv, input int hold,
                      input int e_type, input int e_num, input int e_ovr);
    logic        is_reg;
    logic [31:0] exp_r;
    int          lat, rd_cnt;
    is_reg = !ib && op[4];
    if (is_reg) regs[op[11:8]] = rsv;
    exp_r = ref_result(ib, op, rm, c, rsv);
    @(posedge clk); #1;
    i_bit = ib; operand2 = op; rm_data = rm; carry_in = c; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check("accept_ready", in_ready, 1);
    check("rs_rd_en", rs_rd_en, is_reg);
    if (is_reg) check("rs_addr", rs_addr, op[11:8]);
    @(posedge clk); #1;
    in_valid = 1'($urandom_range(0, 1)); operand2 = 12'($urandom); rm_data = $urandom;
    carry_in = 1'($urandom); i_bit = 1'($urandom);
    lat = 0;
    rd_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (rs_rd_en) rd_cnt++;
    end while (!out_valid && lat < 10);
    check("latency", lat, is_reg ? 1 + RS_LAT : 1);
    check("rd_once", rd_cnt, 0);
    check("busy_ready", in_ready, 0);
    check("result", dut_result(), exp_r);
    if (e_type >= 0) check("type", shift_type, e_type);
    if (e_num >= 0)  check("num", shift_num, e_num);
    if (e_ovr >= 0)  check("ovr_en", ovr_en, e_ovr);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", dut_result(), exp_r);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("done_valid", out_valid, 0);
    check("done_ready", in_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] hs_op [3];
    logic        hs_ib [3];
    logic [31:0] hs_rm [3];
    logic [31:0] hs_exp [3];
    int          idx, got;
    logic        acc;

    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    for (int i = 0; i < RS_LAT; i++) begin
      pv[i] = 1'b0;
      pa[i] = 4'd0;
    end

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_rs_rd_en", rs_rd_en, 0);
    check("rst_rs_addr", rs_addr, 0);
    check("rst_ovr_en", ovr_en, 0);
    check("rst_type", shift_type, 0);
    check("rst_num", shift_num, 0);
    check("rst_x", shift_x, 0);
    check("rst_ovr_val", ovr_val, 0);
    reset_n = 1'b1;

    // Rotate immediate, hold, then reset in the second hold cycle.
    @(posedge clk); #1;
    i_bit = 1'b1; operand2 = 12'h4FF; rm_data = $urandom; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("ri_valid", out_valid, 1);
    check("ri_type", shift_type, 3);
    check("ri_num", shift_num, 8);
    check("ri_x", shift_x, 32'h000000FF);
    check("ri_ovr", ovr_en, 0);
    @(negedge clk);
    check("ri_hold_num", shift_num, 8);
    check("ri_hold_x", shift_x, 32'h000000FF);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_num", shift_num, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset while waiting on Rs: the late read data must not produce an output.
    regs[2] = 32'h00000005;
    @(posedge clk); #1;
    i_bit = 1'b0; operand2 = 12'h211; rm_data = 32'h12345678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rsw_rst_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rsw_rst_quiet", out_valid, 0);
    end

    send(1'b0, 12'h083, 32'hFFFFFFFF, 1'b0, 32'd0, 1, 0, 1, 0);
    send(1'b0, 12'h020, 32'h80000000, 1'b0, 32'd0, 0, -1, -1, 1);
    send(1'b0, 12'h040, 32'h80000001, 1'b0, 32'd0, 0, -1, -1, 1);
    send(1'b0, 12'h040, 32'h7FFFFFFF, 1'b0, 32'd0, 0, -1, -1, 1);
    send(1'b0, 12'h211, 32'hCAFEF00D, 1'b0, 32'h00000105, 2, 0, 5, 0);
    send(1'b0, 12'h211, 32'hCAFEF00D, 1'b0, 32'h00000020, 0, -1, -1, 1);
    send(1'b0, 12'h271, 32'h0000F00F, 1'b0, 32'h00000021, 0, 3, 1, 0);
    send(1'b0, 12'h251, 32'h80000000, 1'b0, 32'h00000040, 0, -1, -1, 1);
    send(1'b0, 12'h231, 32'h13579BDF, 1'b0, 32'hFFFFFF00, 0, 0, 0, 0);
`ifdef OPERAND2_RRX_EN
    send(1'b0, 12'h060, 32'h00000003, 1'b1, 32'd0, 0, -1, -1, 1);
`else
    send(1'b0, 12'h060, 32'h00000003, 1'b1, 32'd0, 0, 3, 0, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [31:0] r, rsv;
      logic [7:0]  a;
      case ($urandom_range(0, 5))
        0:       a = 8'd0;
        1:       a = 8'($urandom_range(1, 31));
        2:       a = 8'd32;
        3:       a = 8'd64;
        4:       a = 8'($urandom_range(33, 255));
        default: a = 8'($urandom);
      endcase
      r = $urandom;
      rsv = {r[31:8], a};
      send(1'($urandom_range(0, 3) == 0), 12'($urandom), $urandom, 1'($urandom), rsv,
           $urandom_range(0, 2), -1, -1, -1);
    end

    // Three instructions with in_valid held high and out_ready toggling every cycle.
    hs_ib[0] = 1'b1; hs_op[0] = 12'h3A5; hs_rm[0] = $urandom;
    hs_ib[1] = 1'b0; hs_op[1] = 12'h571; hs_rm[1] = $urandom;
    hs_ib[2] = 1'b0; hs_op[2] = 12'h0C2; hs_rm[2] = 32'h80000010;
    regs[5] = 32'h00000007;
    for (int i = 0; i < 3; i++) hs_exp[i] = ref_result(hs_ib[i], hs_op[i], hs_rm[i], 1'b0, regs[5]);
    @(posedge clk); #1;
    i_bit = hs_ib[0]; operand2 = hs_op[0]; rm_data = hs_rm[0]; carry_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check("hs_result", dut_result(), hs_exp[got]);
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          i_bit = hs_ib[idx]; operand2 = hs_op[idx]; rm_data = hs_rm[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ~out_ready;
    end
    check("hs_count", got, 3);
    check("hs_accepts", idx, 3);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hs_quiet", out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
